// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// state encoding, state enum and counter-width helper.
package mult_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      CALC = ST_CALC,
      DONE = ST_DONE
   } state_t;

   // ceil(log2(w+1)), at least 1
   function automatic int cnt_w(input int w);
      int n;
      n = 1;
      for (int i = 1; i < 32; i++) begin
         if ((1 << i) < (w + 1)) n = i + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/mult_seq_abs.sv
// Conditional two's-complement negate of a W-bit value.
// Ports: x (value in), neg (1 = negate), y (result out).
module mult_seq_abs #(
   parameter int W = 16
) (
   input  logic [W-1:0] x,
   input  logic         neg,
   output logic [W-1:0] y
);

   assign y = neg ? -x : x;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, WIDTH cycles per product, with
// valid/ready on both sides and optional per-transaction signedness.
// Ports: clk, reset (sync, active low), in_valid/in_ready/a/b/in_signed
// (operand side), out_valid/out_ready/product (result side).
module mult_seq #(
   parameter int WIDTH     = 16,
   parameter int SIGNED_EN = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] product
);

   import mult_pkg::*;

   localparam int PW = 2 * WIDTH;
   localparam int CW = cnt_w(WIDTH);

   state_t           state;
   state_t           state_nx;
   logic [CW-1:0]    count;
   logic [PW-1:0]    mcand;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    acc_nx;
   logic [PW-1:0]    prod_fix;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic             neg;
   logic             eff;
   logic             last;

   assign eff = in_signed & (SIGNED_EN != 0);

   mult_seq_abs #(.W(WIDTH)) u_abs_a (
      .x   (a),
      .neg (eff & a[WIDTH-1]),
      .y   (abs_a)
   );

   mult_seq_abs #(.W(WIDTH)) u_abs_b (
      .x   (b),
      .neg (eff & b[WIDTH-1]),
      .y   (abs_b)
   );

   // mcand is pre-shifted each cycle, so it always equals
   // |a| << count and no barrel shifter is needed.
   assign acc_nx = mplier[0] ? acc + mcand : acc;
   assign last   = (count == CW'(WIDTH - 1));

   mult_seq_abs #(.W(PW)) u_fix (
      .x   (acc_nx),
      .neg (neg),
      .y   (prod_fix)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nx = CALC;
         end
         CALC: begin
            if (last) state_nx = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count   <= '0;
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         neg     <= 1'b0;
         product <= '0;
      end else if (state == IDLE) begin
         if (in_valid) begin
            mcand  <= {{WIDTH{1'b0}}, abs_a};
            mplier <= abs_b;
            acc    <= '0;
            count  <= '0;
            neg    <= eff & (a[WIDTH-1] ^ b[WIDTH-1]);
         end
      end else if (state == CALC) begin
         acc    <= acc_nx;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         count  <= count + CW'(1);
         if (last) product <= prod_fix;
      end
   end

endmodule

// File: tb/tb_mult_seq.sv
// Testbench for mult_seq: directed corners, random operands against
// an arithmetic reference, backpressure, reset abort, unsigned-only build.
module tb_mult_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        s = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] product;

   logic        u_in_valid = 1'b0;
   logic        u_in_ready;
   logic [15:0] u_a = '0;
   logic [15:0] u_b = '0;
   logic        u_s = 1'b0;
   logic        u_out_valid;
   logic        u_out_ready = 1'b0;
   logic [31:0] u_product;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   mult_seq #(.WIDTH(16), .SIGNED_EN(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .in_signed (s),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   mult_seq #(.WIDTH(16), .SIGNED_EN(0)) dut_u (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (u_in_valid),
      .in_ready  (u_in_ready),
      .a         (u_a),
      .b         (u_b),
      .in_signed (u_s),
      .out_valid (u_out_valid),
      .out_ready (u_out_ready),
      .product   (u_product)
   );

   function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y, input logic sg);
      longint xv;
      longint yv;
      longint p;
      xv = sg ? longint'($signed(x)) : longint'(x);
      yv = sg ? longint'($signed(y)) : longint'(y);
      p  = xv * yv;
      return p[31:0];
   endfunction

   // Accept one operation and wait for out_valid; lat = edges from
   // accept edge to out_valid (inclusive), -1 on timeout.
   task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic sg, output int lat, output logic [31:0] p);
      int n;
      n = 0;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1; n++;
      end
      a = x; b = y; s = sg; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 16'($urandom); b = 16'($urandom); s = 1'($urandom);
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      lat = out_valid ? n : -1;
      p = product;
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errs++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++;
      if (product !== 32'h0) begin errs++; $display("FAIL reset_product got=%h exp=0", product); end
      reset = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_directed();
      logic [15:0] ta [5] = '{16'd3, 16'hFFFF, 16'hFFFF, 16'h8000, 16'hFFFD};
      logic [15:0] tb [5] = '{16'd5, 16'hFFFF, 16'hFFFF, 16'h8000, 16'd7};
      logic        ts [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [31:0] te [5] = '{32'h0000000F, 32'hFFFE0001, 32'h00000001, 32'h40000000, 32'hFFFFFFEB};
      int lat;
      logic [31:0] p;
      for (int i = 0; i < 5; i++) begin
         do_op(ta[i], tb[i], ts[i], lat, p);
         checks++;
         if (lat != 17) begin errs++; $display("FAIL dir_latency[%0d] got=%0d exp=17", i, lat); end
         checks++;
         if (p !== te[i]) begin errs++; $display("FAIL dir_product[%0d] got=%h exp=%h", i, p, te[i]); end
         release_out();
      end
   endtask

   task automatic test_random();
      int lat;
      logic [31:0] p;
      logic [15:0] x;
      logic [15:0] y;
      logic sg;
      for (int i = 0; i < 30; i++) begin
         x = 16'($urandom); y = 16'($urandom); sg = 1'($urandom);
         if (i % 7 == 0) x = 16'h8000;
         if (i % 5 == 0) y = 16'hFFFF;
         do_op(x, y, sg, lat, p);
         checks++;
         if (lat != 17) begin errs++; $display("FAIL rnd_latency[%0d] got=%0d exp=17", i, lat); end
         checks++;
         if (p !== ref_mul(x, y, sg)) begin
            errs++;
            $display("FAIL rnd_product[%0d] a=%h b=%h s=%b got=%h exp=%h", i, x, y, sg, p, ref_mul(x, y, sg));
         end
         release_out();
      end
   endtask

   task automatic test_zero();
      int lat;
      logic [31:0] p;
      do_op(16'h0, 16'hBEEF, 1'b1, lat, p);
      checks++;
      if (lat != 17) begin errs++; $display("FAIL zero_latency got=%0d exp=17", lat); end
      checks++;
      if (p !== 32'h0) begin errs++; $display("FAIL zero_product got=%h exp=0", p); end
      release_out();
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      logic [31:0] p;
      logic [31:0] e;
      e = ref_mul(16'd1234, 16'd567, 1'b0);
      do_op(16'd1234, 16'd567, 1'b0, lat, p);
      checks++;
      if (p !== e) begin errs++; $display("FAIL bp_product got=%h exp=%h", p, e); end
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            a = 16'd7; b = 16'd7; s = 1'b0; in_valid = 1'b1;
         end
         @(posedge clk); #1;
         in_valid = 1'b0;
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== e) begin
            errs++;
            $display("FAIL bp_stall[%0d] ov=%b ir=%b prod=%h exp ov=1 ir=0 prod=%h", i, out_valid, in_ready, product, e);
         end
      end
      release_out();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errs++;
         $display("FAIL bp_release ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
      end
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
      end
      checks++;
      if (bad != 0) begin errs++; $display("FAIL bp_ignored bad_cycles=%0d exp=0", bad); end
      checks++;
      if (product !== e) begin errs++; $display("FAIL idle_hold got=%h exp=%h", product, e); end
   endtask

   task automatic test_back_to_back();
      int lat;
      int n;
      logic [31:0] p;
      do_op(16'hFFF0, 16'd33, 1'b1, lat, p);
      a = 16'd321; b = 16'hF00D; s = 1'b1;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errs++;
         $display("FAIL b2b_out_only ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (in_ready !== 1'b0) begin errs++; $display("FAIL b2b_accept ir=%b exp=0", in_ready); end
      n = 1;
      while (!out_valid && n < 100) begin
         @(posedge clk); #1; n++;
      end
      checks++;
      if (n != 17) begin errs++; $display("FAIL b2b_latency got=%0d exp=17", n); end
      checks++;
      if (product !== ref_mul(16'd321, 16'hF00D, 1'b1)) begin
         errs++;
         $display("FAIL b2b_product got=%h exp=%h", product, ref_mul(16'd321, 16'hF00D, 1'b1));
      end
      release_out();
   endtask

   task automatic test_reset_mid();
      int lat;
      int bad;
      logic [31:0] p;
      a = 16'd100; b = 16'd200; s = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || product !== 32'h0) begin
         errs++;
         $display("FAIL rst_mid ir=%b ov=%b prod=%h exp ir=1 ov=0 prod=0", in_ready, out_valid, product);
      end
      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin errs++; $display("FAIL rst_abort_ov bad_cycles=%0d exp=0", bad); end
      do_op(16'd2, 16'd9, 1'b0, lat, p);
      checks++;
      if (p !== 32'd18 || lat != 17) begin
         errs++;
         $display("FAIL rst_fresh prod=%h lat=%0d exp prod=00000012 lat=17", p, lat);
      end
      release_out();
   endtask

   task automatic test_unsigned_inst();
      logic [15:0] x;
      logic [15:0] y;
      logic [31:0] e;
      int n;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) begin
            x = 16'hFFFF; y = 16'd2;
         end else begin
            x = 16'($urandom); y = 16'($urandom) | 16'h8000;
         end
         e = (i == 0) ? 32'h0001FFFE : ref_mul(x, y, 1'b0);
         u_a = x; u_b = y; u_s = 1'b1; u_in_valid = 1'b1;
         @(posedge clk); #1;
         u_in_valid = 1'b0;
         n = 1;
         while (!u_out_valid && n < 100) begin
            @(posedge clk); #1; n++;
         end
         checks++;
         if (n != 17 || u_product !== e) begin
            errs++;
            $display("FAIL unsigned_inst[%0d] prod=%h lat=%0d exp prod=%h lat=17", i, u_product, n, e);
         end
         u_out_ready = 1'b1;
         @(posedge clk); #1;
         u_out_ready = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_zero();
      test_random();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_unsigned_inst();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised sequential shift-add multiplier. Successor to the two-state load/calc 16-bit multiplier.
- Operand width is generic. Signedness is selectable per transaction.
- Input and output use valid/ready handshakes; the result is held until the consumer accepts it.
- Sits between an operand producer and a result consumer in the datapath. Trades WIDTH cycles of latency for a single adder.

Parameters:
- WIDTH, 16, operand width in bits (2..32); product is 2*WIDTH bits.
- SIGNED_EN, 1, 1 = in_signed port honoured; 0 = in_signed ignored, all operations unsigned.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (sampled on rising edge of clk; 0 = reset).
- in_valid  input  1  operands a, b, in_signed valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- in_signed  input  1  1 = two's-complement operands and product; 0 = unsigned.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- product  output  2*WIDTH  result.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; counter=0; product=0; out_valid=0; in_ready=1.
  - Internal operand and accumulator registers are cleared.
  - Reset mid-operation aborts the operation; no out_valid is produced for the aborted transaction.
- States:
  - IDLE: in_ready=1, out_valid=0. in_valid=1 at posedge (accept) latches the operands, clears the accumulator, sets counter=0, goes to CALC.
  - CALC: in_ready=0, out_valid=0. One multiplier bit per cycle, LSB first:
    - if the current bit is 1, acc += multiplicand << counter;
    - counter++.
    - After the WIDTH-th CALC cycle: product <= sign-corrected acc; go to DONE.
  - DONE: out_valid=1, in_ready=0, product stable. out_ready=1 at posedge goes to IDLE, drops out_valid.
- Latency:
  - out_valid rises after exactly WIDTH+1 posedges following the accept edge (accept edge, then WIDTH CALC edges).
  - Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH CALC cycles, one DONE cycle, then back in IDLE).
- Signed mode (eff_signed = in_signed & SIGNED_EN, latched at accept):
  - Magnitudes |a| and |b| are latched as WIDTH-bit unsigned values; the most-negative value's magnitude 2^(WIDTH-1) fits unsigned.
  - neg = a[MSB] ^ b[MSB] is latched.
  - Final product = neg ? -acc : acc, taken modulo 2^(2*WIDTH).
  - Unsigned mode uses a and b as-is, neg=0.
- Width rules:
  - acc is 2*WIDTH bits. The unsigned max (2^WIDTH-1)^2 fits without overflow.
  - Signed (-2^(W-1))^2 = 2^(2W-2) fits as positive.
- Boundary conditions:
  - in_valid while busy (CALC/DONE) is ignored, since in_ready=0. The producer must hold its operands.
  - in_valid with out_ready in the same cycle during DONE: only the output handshake completes; the new input is accepted in IDLE on the next edge.
  - out_ready held low keeps the block in DONE indefinitely; product must not change.
  - Operand 0: full latency still applies (no early termination); product=0.
  - a, b and in_signed changing during CALC have no effect.
- product holds its last value in IDLE; it is only updated on the CALC-to-DONE transition and on reset.

Decomposition:
- Shared package mult_pkg:
  - state encoding localparams ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2;
  - helper function for counter width, ceil(log2(WIDTH+1)).
- Optional sub-module mult_seq_abs (WIDTH-bit conditional two's-complement negate), instantiated for |a|, |b| and, at 2*WIDTH, for the final sign correction.
- Everything else stays in one always block plus output assigns.

Test Plan (WIDTH=16, SIGNED_EN=1):
- Unsigned: a=3, b=5, in_signed=0 -> out_valid exactly 17 edges after accept; product=32'h0000000F.
- Unsigned max: a=16'hFFFF, b=16'hFFFF, in_signed=0 -> product=32'hFFFE0001. The same operands with in_signed=1 (i.e. -1 * -1) -> product=32'h00000001.
- Signed corners:
  - a=16'h8000, b=16'h8000, in_signed=1 -> product=32'h40000000;
  - a=-3 (16'hFFFD), b=7, in_signed=1 -> product=32'hFFFFFFEB.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> product and out_valid stable, in_ready=0. Pulse in_valid with new operands during the stall -> ignored. After out_ready=1 -> in_ready=1 on the next cycle.
- Reset mid-operation: accept a=100, b=200, drive reset=0 on the 5th CALC cycle -> next cycle in_ready=1, out_valid=0, product=0. A fresh accept of a=2, b=9 -> product=32'd18.
- SIGNED_EN=0 instance: a=16'hFFFF, b=2, in_signed=1 -> product=32'h0001FFFE (unsigned result).
